// File: rtl/lcd_gpu_pkg.sv
// Shared types and defaults for the GPU-to-LCD 8080 byte-serial stream.
package lcd_gpu_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SYNC,
      S_CMD,
      S_PIX_WAIT,
      S_PIX_HI,
      S_PIX_LO
   } state_t;

   localparam logic [7:0]  CMD_RAMWR_DEFAULT = 8'h2C;
   localparam int unsigned N_PIXELS_DEFAULT  = 76800;

endpackage

// File: rtl/lcd_wr_strobe.sv
// 8080 byte-write timing: lcd_wr_n low for WR_CYCLES clocks, then high for WR_CYCLES clocks.
module lcd_wr_strobe #(
   parameter int unsigned WR_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] wr_byte,
   input  logic       rs,
   output logic [7:0] lcd_d,
   output logic       lcd_rs,
   output logic       lcd_wr_n,
   output logic       done
);

   localparam int unsigned    CW   = $clog2(WR_CYCLES + 1);
   localparam logic [CW-1:0]  LAST = CW'(WR_CYCLES - 1);

   logic          active;
   logic [CW-1:0] cnt;

   // start may arrive in the done cycle so consecutive bytes run with no gap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lcd_d    <= '0;
         lcd_rs   <= 1'b1;
         lcd_wr_n <= 1'b1;
         active   <= 1'b0;
         cnt      <= '0;
      end else if (start) begin
         lcd_d    <= wr_byte;
         lcd_rs   <= rs;
         lcd_wr_n <= 1'b0;
         active   <= 1'b1;
         cnt      <= '0;
      end else if (active) begin
         if (cnt == LAST) begin
            cnt <= '0;
            if (!lcd_wr_n) lcd_wr_n <= 1'b1;
            else           active   <= 1'b0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

   assign done = active & lcd_wr_n & (cnt == LAST);

endmodule

// File: rtl/lcd_gpu_stream.sv
// RGB565 valid/ready stream to 8080 LCD bus, each frame prefixed by RAMWR.
// Define LCD_GPU_STREAM_FMARK_SYNC_EN to align frame starts to rising edges of lcd_fmark.
module lcd_gpu_stream
   import lcd_gpu_pkg::*;
#(
   parameter int unsigned N_PIXELS  = N_PIXELS_DEFAULT,
   parameter int unsigned WR_CYCLES = 2,
   parameter logic [7:0]  CMD_RAMWR = CMD_RAMWR_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic [15:0] gpu_data,
   input  logic        gpu_valid,
   output logic        gpu_ready,
   output logic [7:0]  lcd_d,
   output logic        lcd_rs,
   output logic        lcd_wr_n,
   input  logic        lcd_fmark,
   output logic        busy,
   output logic        frame_done
);

   localparam int unsigned CNT_W = $clog2(N_PIXELS + 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [7:0]       hold_lo;
   logic             cmd_go;
   logic             hs;
   logic             start;
   logic             wr_done;
   logic             rs;
   logic [7:0]       wr_byte;

`ifdef LCD_GPU_STREAM_FMARK_SYNC_EN
   logic [1:0] fm_sync;
   logic       fm_prev;
   logic       fm_edge;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fm_sync <= '0;
         fm_prev <= 1'b0;
      end else begin
         fm_sync <= {fm_sync[0], lcd_fmark};
         fm_prev <= fm_sync[1];
      end
   end

   assign fm_edge = fm_sync[1] & ~fm_prev;
`else
   logic unused_fmark;
   assign unused_fmark = lcd_fmark;
`endif

   assign hs = gpu_valid & gpu_ready;

   // High byte is launched on the handshake edge straight from gpu_data, so only the low byte is held
   always_comb begin
      start   = cmd_go | ((state == S_PIX_WAIT) & hs) | ((state == S_PIX_HI) & wr_done);
      rs      = (state != S_CMD);
      wr_byte = CMD_RAMWR;
      if (state == S_PIX_WAIT)    wr_byte = gpu_data[15:8];
      else if (state == S_PIX_HI) wr_byte = hold_lo;
   end

   lcd_wr_strobe #(.WR_CYCLES(WR_CYCLES)) u_strobe (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .wr_byte  (wr_byte),
      .rs       (rs),
      .lcd_d    (lcd_d),
      .lcd_rs   (lcd_rs),
      .lcd_wr_n (lcd_wr_n),
      .done     (wr_done)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         cnt        <= '0;
         hold_lo    <= '0;
         cmd_go     <= 1'b0;
         gpu_ready  <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         cmd_go     <= 1'b0;
         case (state)
            S_IDLE: if (enable) begin
               busy  <= 1'b1;
`ifdef LCD_GPU_STREAM_FMARK_SYNC_EN
               state <= S_SYNC;
`else
               state  <= S_CMD;
               cmd_go <= 1'b1;
`endif
            end
`ifdef LCD_GPU_STREAM_FMARK_SYNC_EN
            S_SYNC: if (!enable) begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end else if (fm_edge) begin
               state  <= S_CMD;
               cmd_go <= 1'b1;
            end
`endif
            S_CMD: if (wr_done) begin
               cnt       <= CNT_W'(N_PIXELS);
               state     <= S_PIX_WAIT;
               gpu_ready <= 1'b1;
            end
            S_PIX_WAIT: if (hs) begin
               hold_lo   <= gpu_data[7:0];
               gpu_ready <= 1'b0;
               state     <= S_PIX_HI;
            end
            S_PIX_HI: if (wr_done) state <= S_PIX_LO;
            S_PIX_LO: if (wr_done) begin
               cnt <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  frame_done <= 1'b1;
                  busy       <= 1'b0;
                  state      <= S_IDLE;
               end else begin
                  state     <= S_PIX_WAIT;
                  gpu_ready <= 1'b1;
               end
            end
            default: begin
               state     <= S_IDLE;
               busy      <= 1'b0;
               gpu_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_gpu_stream.sv
// Scoreboard bench for lcd_gpu_stream; adapts to whether LCD_GPU_STREAM_FMARK_SYNC_EN is defined.
module tb_lcd_gpu_stream;

   localparam int unsigned NPIX = 4;
   localparam int unsigned WRC  = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic [15:0] gpu_data = '0;
   logic        gpu_valid = 1'b0;
   logic        lcd_fmark = 1'b0;
   logic        gpu_ready, lcd_rs, lcd_wr_n, busy, frame_done;
   logic [7:0]  lcd_d;

   int n_checks = 0;
   int n_fail   = 0;

   logic [8:0] exp_q[$];
   int         rd_idx = 0;

   int         cyc = 0;
   int         cap_cnt = 0;
   logic [8:0] cap_val [0:255];
   int         cap_cyc [0:255];
   int         fd_cnt = 0;
   int         fd_cyc = 0;
   logic       prev_wr = 1'b1;

   always #5 clk = ~clk;

   lcd_gpu_stream #(.N_PIXELS(NPIX), .WR_CYCLES(WRC), .CMD_RAMWR(8'h2C)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .gpu_data   (gpu_data),
      .gpu_valid  (gpu_valid),
      .gpu_ready  (gpu_ready),
      .lcd_d      (lcd_d),
      .lcd_rs     (lcd_rs),
      .lcd_wr_n   (lcd_wr_n),
      .lcd_fmark  (lcd_fmark),
      .busy       (busy),
      .frame_done (frame_done)
   );

   // Bus monitor: capture {rs,d} on each lcd_wr_n rise, count frame_done pulses
   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (!rst_n) begin
         prev_wr <= 1'b1;
      end else begin
         prev_wr <= lcd_wr_n;
         if (lcd_wr_n && !prev_wr && cap_cnt < 256) begin
            cap_val[cap_cnt] <= {lcd_rs, lcd_d};
            cap_cyc[cap_cnt] <= cyc;
            cap_cnt          <= cap_cnt + 1;
         end
         if (frame_done) begin
            fd_cnt <= fd_cnt + 1;
            fd_cyc <= cyc;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(negedge clk);
      #1;
   endtask

   task automatic pulse_fmark;
      lcd_fmark = 1'b1;
      repeat (3) tick;
      lcd_fmark = 1'b0;
   endtask

   task automatic push_pixel(input logic [15:0] px);
      bit ok = 1'b0;
      gpu_data  = px;
      gpu_valid = 1'b1;
      exp_q.push_back({1'b1, px[15:8]});
      exp_q.push_back({1'b1, px[7:0]});
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (gpu_ready) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
      gpu_valid = 1'b0;
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL handshake %h: got no gpu_ready, expected acceptance within 300 cycles", px);
      end
   endtask

   task automatic wait_frames(input int target);
      for (int i = 0; i < 400 && fd_cnt < target; i++) tick;
      n_checks++;
      if (fd_cnt < target) begin
         n_fail++;
         $display("FAIL frame_done_wait: got count %0d, expected %0d", fd_cnt, target);
      end
   endtask

   task automatic check_scoreboard(input string tag);
      logic [8:0] e, g;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = (rd_idx < cap_cnt) ? cap_val[rd_idx] : 'x;
         n_checks++;
         if (g !== e) begin
            n_fail++;
            $display("FAIL %s byte %0d: got rs/d %h, expected %h", tag, rd_idx, g, e);
         end
         rd_idx++;
      end
      n_checks++;
      if (cap_cnt != rd_idx) begin
         n_fail++;
         $display("FAIL %s byte_count: got %0d captures, expected %0d", tag, cap_cnt, rd_idx);
      end
      rd_idx = cap_cnt;
   endtask

   task automatic test_reset;
      bit seen = 1'b0;
      repeat (3) tick;
      n_checks += 6;
      if (lcd_d !== 8'h00)   begin n_fail++; $display("FAIL rst_lcd_d: got %h, expected 00", lcd_d); end
      if (lcd_rs !== 1'b1)   begin n_fail++; $display("FAIL rst_lcd_rs: got %b, expected 1", lcd_rs); end
      if (lcd_wr_n !== 1'b1) begin n_fail++; $display("FAIL rst_lcd_wr_n: got %b, expected 1", lcd_wr_n); end
      if (gpu_ready !== 1'b0) begin n_fail++; $display("FAIL rst_gpu_ready: got %b, expected 0", gpu_ready); end
      if (busy !== 1'b0)     begin n_fail++; $display("FAIL rst_busy: got %b, expected 0", busy); end
      if (frame_done !== 1'b0) begin n_fail++; $display("FAIL rst_frame_done: got %b, expected 0", frame_done); end
      rst_n = 1'b1;
      tick;
      // start a frame and hit it with reset while lcd_wr_n is low
      enable    = 1'b1;
      lcd_fmark = 1'b1;
      for (int i = 0; i < 50; i++) begin
         tick;
         if (lcd_wr_n === 1'b0) begin
            seen = 1'b1;
            break;
         end
      end
      n_checks++;
      if (!seen) begin n_fail++; $display("FAIL midbyte_wr_low: got lcd_wr_n %b, expected 0 within 50 cycles", lcd_wr_n); end
      #2;
      rst_n     = 1'b0;
      lcd_fmark = 1'b0;
      #1;
      n_checks += 5;
      if (lcd_wr_n !== 1'b1) begin n_fail++; $display("FAIL async_wr_n: got %b, expected 1", lcd_wr_n); end
      if (lcd_d !== 8'h00)   begin n_fail++; $display("FAIL async_lcd_d: got %h, expected 00", lcd_d); end
      if (lcd_rs !== 1'b1)   begin n_fail++; $display("FAIL async_lcd_rs: got %b, expected 1", lcd_rs); end
      if (busy !== 1'b0)     begin n_fail++; $display("FAIL async_busy: got %b, expected 0", busy); end
      if (gpu_ready !== 1'b0) begin n_fail++; $display("FAIL async_gpu_ready: got %b, expected 0", gpu_ready); end
      enable = 1'b0;
      repeat (2) tick;
      rst_n = 1'b1;
      repeat (2) tick;
      rd_idx = cap_cnt;
      exp_q.delete();
   endtask

`ifdef LCD_GPU_STREAM_FMARK_SYNC_EN
   task automatic test_stream;
      int base = rd_idx;
      int fd0  = fd_cnt;
      enable = 1'b1;
      repeat (2) tick;
      exp_q.push_back({1'b0, 8'h2C});
      pulse_fmark;
      push_pixel(16'h1234);
      push_pixel(16'hABCD);
      push_pixel(16'h0000);
      push_pixel(16'hFFFF);
      wait_frames(fd0 + 1);
      repeat (5) tick;
      n_checks++;
      if (fd_cnt != fd0 + 1) begin n_fail++; $display("FAIL stream_done_pulses: got %0d, expected 1", fd_cnt - fd0); end
      n_checks++;
      if (cap_cnt < base + 9) begin
         n_fail++;
         $display("FAIL stream_captures: got %0d, expected 9", cap_cnt - base);
      end else begin
         for (int p = 1; p < 4; p++) begin
            n_checks++;
            if (cap_cyc[base + 1 + 2*p] - cap_cyc[base - 1 + 2*p] != 1 + 4*WRC) begin
               n_fail++;
               $display("FAIL pixel_spacing %0d: got %0d clocks, expected %0d", p,
                        cap_cyc[base + 1 + 2*p] - cap_cyc[base - 1 + 2*p], 1 + 4*WRC);
            end
         end
         n_checks += 2;
         if (cap_cyc[base + 2] - cap_cyc[base + 1] != 2*WRC) begin
            n_fail++;
            $display("FAIL byte_period: got %0d clocks, expected %0d", cap_cyc[base + 2] - cap_cyc[base + 1], 2*WRC);
         end
         if (fd_cyc - cap_cyc[base + 8] != WRC) begin
            n_fail++;
            $display("FAIL frame_done_timing: got %0d clocks after last rise, expected %0d", fd_cyc - cap_cyc[base + 8], WRC);
         end
      end
      check_scoreboard("stream");
   endtask

   task automatic test_stall;
      bit ok = 1'b0;
      int fd0 = fd_cnt;
      exp_q.push_back({1'b0, 8'h2C});
      pulse_fmark;
      push_pixel(16'h5A3C);
      push_pixel(16'h0F0F);
      for (int i = 0; i < 50; i++) begin
         tick;
         if (lcd_wr_n === 1'b1 && gpu_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL stall_enter: got ready %b wr_n %b, expected 1/1", gpu_ready, lcd_wr_n); end
      for (int i = 0; i < 20; i++) begin
         tick;
         n_checks++;
         if (lcd_wr_n !== 1'b1 || gpu_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_gap cycle %0d: got wr_n %b ready %b, expected 1 1", i, lcd_wr_n, gpu_ready);
         end
      end
      push_pixel(16'hC3A5);
      push_pixel(16'h8001);
      wait_frames(fd0 + 1);
      repeat (3) tick;
      check_scoreboard("stall");
   endtask

   task automatic test_enable_drop;
      int fd0 = fd_cnt;
      exp_q.push_back({1'b0, 8'h2C});
      pulse_fmark;
      push_pixel(16'h1111);
      enable = 1'b0;
      push_pixel(16'h2222);
      push_pixel(16'h3333);
      push_pixel(16'h4444);
      wait_frames(fd0 + 1);
      repeat (5) tick;
      check_scoreboard("enable_drop");
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL enable_drop_idle: got busy %b, expected 0", busy); end
      pulse_fmark;
      repeat (20) tick;
      n_checks += 2;
      if (cap_cnt != rd_idx) begin n_fail++; $display("FAIL enable_drop_ramwr: got %0d new bytes, expected 0", cap_cnt - rd_idx); end
      if (busy !== 1'b0) begin n_fail++; $display("FAIL enable_drop_busy: got %b, expected 0", busy); end
   endtask

   task automatic test_fmark_midframe;
      int fd0 = fd_cnt;
      enable = 1'b1;
      exp_q.push_back({1'b0, 8'h2C});
      pulse_fmark;
      push_pixel(16'hDEAD);
      push_pixel(16'hBEEF);
      pulse_fmark;
      push_pixel(16'h0102);
      push_pixel(16'hFEDC);
      wait_frames(fd0 + 1);
      repeat (3) tick;
      check_scoreboard("midframe");
      repeat (30) tick;
      n_checks += 2;
      if (cap_cnt != rd_idx) begin n_fail++; $display("FAIL midframe_no_restart: got %0d new bytes, expected 0", cap_cnt - rd_idx); end
      if (busy !== 1'b1) begin n_fail++; $display("FAIL midframe_waiting: got busy %b, expected 1", busy); end
      exp_q.push_back({1'b0, 8'h2C});
      pulse_fmark;
      push_pixel(16'h7E81);
      push_pixel(16'h00FF);
      push_pixel(16'hFF00);
      push_pixel(16'h55AA);
      enable = 1'b0;
      wait_frames(fd0 + 2);
      repeat (3) tick;
      check_scoreboard("next_frame");
   endtask
`else
   task automatic test_back_to_back;
      int fd0 = fd_cnt;
      enable = 1'b1;
      exp_q.push_back({1'b0, 8'h2C});
      tick;
      n_checks++;
      if (lcd_wr_n !== 1'b1 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL idle_to_cmd: got wr_n %b busy %b, expected 1 1", lcd_wr_n, busy);
      end
      tick;
      n_checks++;
      if (lcd_wr_n !== 1'b0 || lcd_d !== 8'h2C || lcd_rs !== 1'b0) begin
         n_fail++;
         $display("FAIL ramwr_issue: got wr_n %b d %h rs %b, expected 0 2c 0", lcd_wr_n, lcd_d, lcd_rs);
      end
      push_pixel(16'h1234);
      push_pixel(16'hABCD);
      push_pixel(16'h0000);
      push_pixel(16'hFFFF);
      exp_q.push_back({1'b0, 8'h2C});
      push_pixel(16'h9876);
      enable = 1'b0;
      push_pixel(16'h0F1E);
      push_pixel(16'h2D3C);
      push_pixel(16'h4B5A);
      wait_frames(fd0 + 2);
      repeat (20) tick;
      check_scoreboard("back_to_back");
      n_checks += 2;
      if (fd_cnt != fd0 + 2) begin n_fail++; $display("FAIL b2b_frames: got %0d, expected 2", fd_cnt - fd0); end
      if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got busy %b, expected 0", busy); end
   endtask
`endif

   initial begin
      test_reset;
`ifdef LCD_GPU_STREAM_FMARK_SYNC_EN
      test_stream;
      test_stall;
      test_enable_drop;
      test_fmark_midframe;
`else
      test_back_to_back;
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
